// File: rtl/nes_tetris_sdram_ctrl.sv
// Single-port controller for a 16-bit SDR SDRAM (4 banks, 13-bit row, 10-bit column).
// Power-up init, periodic auto-refresh, and single-word closed-page (auto-precharge)
// reads and writes through a req/ack host port.
//
// Ports:
//   i_clk, i_reset_n         system clock (also the SDRAM clock), async active-low reset
//   i_req, i_wr, i_addr      host request (held until o_ack), direction, word address
//   i_wdata, i_be            write data and byte enables
//   o_ack                    one-cycle pulse when the column command issues
//   o_rdata, o_rvalid        read data and its one-cycle valid strobe
//   o_busy, o_init_done      controller not idle / init sequence complete
//   o_zs_*, io_zs_dq         registered SDRAM pins and data bus
module nes_tetris_sdram_ctrl #(
  parameter int unsigned INIT_WAIT        = 10000,
  parameter int unsigned REFRESH_INTERVAL = 780,
  parameter int unsigned CAS_LATENCY      = 3,
  parameter int unsigned T_RP             = 2,
  parameter int unsigned T_RCD            = 2,
  parameter int unsigned T_RFC            = 7,
  parameter int unsigned T_MRD            = 2,
  parameter int unsigned T_WR             = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [24:0] i_addr,
  input  logic [15:0] i_wdata,
  input  logic [1:0]  i_be,
  output logic        o_ack,
  output logic [15:0] o_rdata,
  output logic        o_rvalid,
  output logic        o_busy,
  output logic        o_init_done,
  output logic [12:0] o_zs_addr,
  output logic [1:0]  o_zs_ba,
  output logic        o_zs_cas_n,
  output logic        o_zs_cke,
  output logic        o_zs_cs_n,
  output logic [1:0]  o_zs_dqm,
  output logic        o_zs_ras_n,
  output logic        o_zs_we_n,
  inout  wire  [15:0] io_zs_dq
);

  // {ras_n, cas_n, we_n}
  localparam logic [2:0] CmdLmr = 3'b000;
  localparam logic [2:0] CmdRef = 3'b001;
  localparam logic [2:0] CmdPre = 3'b010;
  localparam logic [2:0] CmdAct = 3'b011;
  localparam logic [2:0] CmdWr  = 3'b100;
  localparam logic [2:0] CmdRd  = 3'b101;
  localparam logic [2:0] CmdNop = 3'b111;

  typedef enum logic [2:0] {
    StInitWait, StInitPre, StInitRef1, StInitRef2, StInitLmr, StIdle, StCol, StWait
  } state_e;

  state_e      r_state, w_state_d, r_ret, w_ret_d, w_wait_tgt;
  logic [15:0] r_cnt, w_cnt_d, w_wait_n;
  logic        w_go;

  logic        r_init_done, r_ref_pend;
  logic [15:0] r_ref_cnt;
  logic        r_wr;
  logic [1:0]  r_bank, r_be;
  logic [9:0]  r_col;
  logic [15:0] r_wdata;

  logic [2:0]  r_cmd, w_cmd;
  logic        r_cke, r_cs_n;
  logic [12:0] r_zs_addr, w_a;
  logic [1:0]  r_zs_ba, w_ba, r_dqm, w_dqm;
  logic        r_dq_oe, w_dq_oe;
  logic [15:0] r_dq_out;
  logic        r_ack, w_ack, w_rd, w_latch, w_ref_clr;
  logic [CAS_LATENCY:0] r_rd_pipe;
  logic [15:0] r_rdata;
  logic        r_rvalid;

  always_comb begin
    w_state_d  = r_state;
    w_ret_d    = r_ret;
    w_cnt_d    = r_cnt;
    w_cmd      = CmdNop;
    w_a        = '0;
    w_ba       = '0;
    w_dqm      = 2'b11;
    w_dq_oe    = 1'b0;
    w_ack      = 1'b0;
    w_rd       = 1'b0;
    w_latch    = 1'b0;
    w_ref_clr  = 1'b0;
    w_go       = 1'b0;
    w_wait_n   = '0;
    w_wait_tgt = StIdle;
    unique case (r_state)
      StInitWait: begin
        if (r_cnt == 16'(INIT_WAIT - 1)) begin
          w_state_d = StInitPre;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      StInitPre: begin
        w_cmd      = CmdPre;
        w_a[10]    = 1'b1;  // precharge all banks
        w_go       = 1'b1;
        w_wait_n   = 16'(T_RP);
        w_wait_tgt = StInitRef1;
      end
      StInitRef1: begin
        w_cmd      = CmdRef;
        w_go       = 1'b1;
        w_wait_n   = 16'(T_RFC);
        w_wait_tgt = StInitRef2;
      end
      StInitRef2: begin
        w_cmd      = CmdRef;
        w_go       = 1'b1;
        w_wait_n   = 16'(T_RFC);
        w_wait_tgt = StInitLmr;
      end
      StInitLmr: begin
        w_cmd      = CmdLmr;
        w_a        = {6'b0, 3'(CAS_LATENCY), 4'b0000};  // sequential, burst length 1
        w_go       = 1'b1;
        w_wait_n   = 16'(T_MRD);
        w_wait_tgt = StIdle;
      end
      StIdle: begin
        if (r_ref_pend) begin
          w_cmd      = CmdRef;
          w_ref_clr  = 1'b1;
          w_go       = 1'b1;
          w_wait_n   = 16'(T_RFC);
          w_wait_tgt = StIdle;
        end else if (i_req) begin
          w_cmd      = CmdAct;
          w_ba       = {i_addr[24], i_addr[10]};
          w_a        = i_addr[23:11];
          w_latch    = 1'b1;
          w_go       = 1'b1;
          w_wait_n   = 16'(T_RCD - 1);
          w_wait_tgt = StCol;
        end
      end
      StCol: begin
        w_ba       = r_bank;
        w_a        = {2'b00, 1'b1, r_col};  // A10 selects auto-precharge
        w_ack      = 1'b1;
        w_go       = 1'b1;
        w_wait_tgt = StIdle;
        if (r_wr) begin
          w_cmd    = CmdWr;
          w_dq_oe  = 1'b1;
          w_dqm    = ~r_be;
          w_wait_n = 16'(T_WR + T_RP);
        end else begin
          w_cmd    = CmdRd;
          w_dqm    = 2'b00;
          w_rd     = 1'b1;
          // Return to idle on the cycle rdata is presented; covers tRP.
          w_wait_n = 16'(CAS_LATENCY + 1);
        end
      end
      StWait: begin
        if (r_cnt <= 16'd1) w_state_d = r_ret;
        else                w_cnt_d   = r_cnt - 16'd1;
      end
      default: w_state_d = StInitWait;
    endcase
    // Command states hand off to a shared NOP-wait state.
    if (w_go) begin
      if (w_wait_n == '0) begin
        w_state_d = w_wait_tgt;
      end else begin
        w_state_d = StWait;
        w_cnt_d   = w_wait_n;
        w_ret_d   = w_wait_tgt;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= StInitWait;
      r_ret       <= StIdle;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
      r_ref_pend  <= 1'b0;
      r_ref_cnt   <= '0;
      r_wr        <= 1'b0;
      r_bank      <= '0;
      r_col       <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_cmd       <= CmdNop;
      r_cke       <= 1'b0;
      r_cs_n      <= 1'b1;
      r_zs_addr   <= '0;
      r_zs_ba     <= '0;
      r_dqm       <= 2'b11;
      r_dq_oe     <= 1'b0;
      r_dq_out    <= '0;
      r_ack       <= 1'b0;
      r_rd_pipe   <= '0;
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_ret       <= w_ret_d;
      r_cnt       <= w_cnt_d;
      r_init_done <= r_init_done | (w_state_d == StIdle);
      if (w_latch) begin
        r_wr    <= i_wr;
        r_bank  <= {i_addr[24], i_addr[10]};
        r_col   <= i_addr[9:0];
        r_be    <= i_be;
        r_wdata <= i_wdata;
      end
      if (r_init_done) begin
        if (w_ref_clr) r_ref_pend <= 1'b0;
        if (r_ref_cnt == 16'(REFRESH_INTERVAL - 1)) begin
          r_ref_cnt  <= '0;
          r_ref_pend <= 1'b1;
        end else begin
          r_ref_cnt <= r_ref_cnt + 16'd1;
        end
      end
      r_cmd     <= w_cmd;
      r_cke     <= 1'b1;
      r_cs_n    <= 1'b0;
      r_zs_addr <= w_a;
      r_zs_ba   <= w_ba;
      r_dqm     <= w_dqm;
      r_dq_oe   <= w_dq_oe;
      r_dq_out  <= r_wdata;
      r_ack     <= w_ack;
      // Bit k set means an RD was on the pins k cycles ago.
      r_rd_pipe <= {r_rd_pipe[CAS_LATENCY-1:0], w_rd};
      r_rvalid  <= r_rd_pipe[CAS_LATENCY];
      if (r_rd_pipe[CAS_LATENCY]) r_rdata <= io_zs_dq;
    end
  end

  assign io_zs_dq    = r_dq_oe ? r_dq_out : 16'bz;
  assign o_zs_ras_n  = r_cmd[2];
  assign o_zs_cas_n  = r_cmd[1];
  assign o_zs_we_n   = r_cmd[0];
  assign o_zs_cs_n   = r_cs_n;
  assign o_zs_cke    = r_cke;
  assign o_zs_addr   = r_zs_addr;
  assign o_zs_ba     = r_zs_ba;
  assign o_zs_dqm    = r_dqm;
  assign o_ack       = r_ack;
  assign o_rdata     = r_rdata;
  assign o_rvalid    = r_rvalid;
  assign o_busy      = (r_state != StIdle);
  assign o_init_done = r_init_done;

endmodule

// File: doc/nes_tetris_sdram_ctrl.md
Name: nes_tetris_sdram_ctrl

Overview:
- Single-port SDRAM controller driving the zs_* pin interface of a 16-bit SDR SDRAM (4 banks, 13-bit row, 10-bit column). In simulation it connects to the SDRAM behavioural model.
- Performs power-up initialisation, periodic auto-refresh, and single-word closed-page reads and writes through a simple req/ack host port.
- Sits between the SoC fabric/Tetris frame logic and the SDRAM pins.

Parameters:
- INIT_WAIT, 10000, cycles of NOP after reset before the init sequence (100 us at 100 MHz).
- REFRESH_INTERVAL, 780, cycles between auto-refresh requests.
- CAS_LATENCY, 3, CL programmed by LMR (2 or 3 only).
- T_RP, 2, PRECHARGE to next command (cycles).
- T_RCD, 2, ACTIVE to READ/WRITE (cycles).
- T_RFC, 7, REFRESH to next command (cycles).
- T_MRD, 2, LMR to next command (cycles).
- T_WR, 2, write recovery before auto-precharge completes (cycles).

Ports:
- clk  in  1  system clock; SDRAM clock is the same clock.
- reset_n  in  1  asynchronous active-low reset.
- req  in  1  host request; held until ack.
- wr  in  1  1 = write, 0 = read; qualified by req.
- addr  in  25  word address: [24]=ba[1], [23:11]=row, [10]=ba[0], [9:0]=col.
- wdata  in  16  write data.
- be  in  2  byte enables for writes (dqm = ~be).
- ack  out  1  one-cycle pulse when the column command issues.
- rdata  out  16  read data.
- rvalid  out  1  one-cycle pulse; rdata valid.
- busy  out  1  high whenever the FSM is not in IDLE.
- init_done  out  1  high once the init sequence completes; stays high until reset.
- zs_addr  out  13  SDRAM address.
- zs_ba  out  2  SDRAM bank address.
- zs_cas_n  out  1  SDRAM CAS.
- zs_cke  out  1  SDRAM clock enable.
- zs_cs_n  out  1  SDRAM chip select.
- zs_dqm  out  2  SDRAM data mask.
- zs_ras_n  out  1  SDRAM RAS.
- zs_we_n  out  1  SDRAM WE.
- zs_dq  inout  16  SDRAM data; driven only during the WRITE command cycle.

Behaviour:
- All zs_* outputs are registered.
- Command encodings {ras_n,cas_n,we_n} with cs_n=0: LMR 000, REF 001, PRE 010, ACT 011, WR 100, RD 101, NOP 111.
- Reset state: zs_cke=0, zs_cs_n=1, ras/cas/we=1, zs_addr=0, zs_ba=0, zs_dqm=2'b11, zs_dq hi-Z, ack=0, rvalid=0, rdata=0, busy=1, init_done=0, refresh counter=0, FSM=INIT_WAIT. Asserting reset mid-operation aborts immediately to these values.
- INIT_WAIT: zs_cke=1 from the first cycle after reset release; NOPs for INIT_WAIT cycles.
- INIT_PRE: PRE with a[10]=1, then T_RP NOPs.
- INIT_REF1, INIT_REF2: REF each, each followed by T_RFC NOPs.
- INIT_LMR: LMR with zs_addr = {6'b0, CAS_LATENCY[2:0], 4'b0000} (sequential, burst length 1), zs_ba=0. Then T_MRD NOPs, then init_done=1 and FSM→IDLE.
- Refresh counter: counts every cycle after init_done and sets refresh_pending when it reaches REFRESH_INTERVAL-1, then wraps to 0. refresh_pending clears when REF issues.
- IDLE priority: refresh_pending over req. If both are present in the same cycle, REF issues first and req waits.
- REFRESH: REF, then T_RFC NOPs, then IDLE.
- ACTIVATE: ACT with zs_ba={addr[24],addr[10]}, zs_addr=addr[23:11]; addr, wr, wdata and be are latched. Then T_RCD-1 NOPs.
- Column command (READ or WRITE):
  - zs_addr = {2'b0, 1'b1, col} (A10=1, auto-precharge), same bank as the ACT.
  - ack=1 in this cycle only.
- WRITE: zs_dq=wdata and zs_dqm=~be in the WR cycle only; the bus is hi-Z in every other cycle. Then T_WR+T_RP NOPs, then IDLE.
- READ:
  - RD issues with zs_dqm=2'b00.
  - zs_dq is sampled at the clock edge ending the cycle that lies CAS_LATENCY cycles after the RD cycle.
  - rdata and rvalid appear in the following cycle, so RD cycle n gives rvalid in cycle n+CAS_LATENCY+1.
  - FSM returns to IDLE in the same cycle rvalid is asserted (the wait covers T_RP).
- Non-command cycles: cs_n=0 with NOP; zs_dqm=2'b11 outside read and write windows.
- busy is low only in IDLE. A new req can be accepted no earlier than the cycle after busy falls.
- req dropped before ack: behaviour undefined. The host protocol forbids it.

Test Plan:
- Reset release with INIT_WAIT=20, T_RP=2, T_RFC=7, T_MRD=2 → NOP ×20, PRE(a10=1), REF, REF, LMR with zs_addr=13'h030; init_done rises in cycle 20+1+2+1+7+1+7+1+2 from release (±1, fixed by the bench).
- Write addr=25'h1ABCDEF, wdata=16'hBEEF, be=2'b11, then read the same address → ACT ba=2'b11, row=13'h1579, column a=13'h5EF; ack once per access; rvalid exactly CL+1 cycles after RD with rdata=16'hBEEF. Model contents at that location confirm 16'hBEEF.
- Byte write be=2'b01, wdata=16'h1234, over existing 16'hBEEF → zs_dqm=2'b10 on WR; read back 16'hBE34.
- REFRESH_INTERVAL=50, req asserted in the same cycle refresh_pending sets → REF issued first, ACT follows T_RFC cycles later; no refresh gap exceeds 50 cycles over 1000 cycles.
- CAS_LATENCY=2 instance → LMR zs_addr=13'h020; rvalid 3 cycles after RD with correct data.
- reset_n pulsed low during a read's CL wait → all outputs at reset values asynchronously, no rvalid, init sequence restarts.
